// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the word-addressed PC, runs the req/ack
// handshake to instruction memory and presents instruction/pc+1 to IF/ID.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branchFlag_i,
  input  logic [31:0] branchTarget_i,
  output logic        memReq_o,
  output logic [31:0] memAddr_o,
  input  logic        memAck_i,
  input  logic [31:0] memData_i,
  output logic [31:0] pcPlusOne_o,
  output logic [31:0] instruction_o,
  output logic        stallReq_o,
  output logic [1:0]  dbgState_o
);

  // Handshake: memReq_o stays high with memAddr_o stable until memAck_i;
  // an ack is consumed only in S_FETCH, and acks while memReq_o=0 are ignored.
  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst_buf;
  logic        r_redir_pend;
  logic [31:0] r_redir_tgt;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_inst_buf_nxt;
  logic        w_redir_pend_nxt;
  logic [31:0] w_redir_tgt_nxt;
  logic [31:0] w_pc_inc;

  assign w_pc_inc   = r_pc + 32'd1;
  assign memAddr_o  = r_pc;
  assign dbgState_o = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_PC;
      r_inst_buf   <= NOP_WORD;
      r_redir_pend <= 1'b0;
      r_redir_tgt  <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_inst_buf   <= w_inst_buf_nxt;
      r_redir_pend <= w_redir_pend_nxt;
      r_redir_tgt  <= w_redir_tgt_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_inst_buf_nxt   = r_inst_buf;
    w_redir_pend_nxt = r_redir_pend;
    w_redir_tgt_nxt  = r_redir_tgt;
    memReq_o         = 1'b0;
    stallReq_o       = 1'b1;
    instruction_o    = NOP_WORD;
    pcPlusOne_o      = 32'd0;

    case (r_state)
      S_BOOT: begin
        if (branchFlag_i) begin
          w_pc_nxt         = branchTarget_i;
          w_redir_pend_nxt = 1'b0;
        end
        w_state_nxt = S_FETCH;
      end

      S_FETCH: begin
        memReq_o = 1'b1;
        if (branchFlag_i) begin
          // An outstanding request cannot be withdrawn, so remember the
          // target and retire the request before moving the PC.
          if (memAck_i) begin
            w_pc_nxt         = branchTarget_i;
            w_redir_pend_nxt = 1'b0;
          end else begin
            w_redir_pend_nxt = 1'b1;
            w_redir_tgt_nxt  = branchTarget_i;
          end
        end else if (memAck_i) begin
          if (r_redir_pend) begin
            w_pc_nxt         = r_redir_tgt;
            w_redir_pend_nxt = 1'b0;
          end else begin
            instruction_o = memData_i;
            pcPlusOne_o   = w_pc_inc;
            stallReq_o    = 1'b0;
            if (stall_i) begin
              w_inst_buf_nxt = memData_i;
              w_state_nxt    = S_HOLD;
            end else begin
              w_pc_nxt = w_pc_inc;
            end
          end
        end
      end

      S_HOLD: begin
        stallReq_o    = 1'b0;
        instruction_o = r_inst_buf;
        pcPlusOne_o   = w_pc_inc;
        if (branchFlag_i) begin
          w_pc_nxt         = branchTarget_i;
          w_redir_pend_nxt = 1'b0;
          w_state_nxt      = S_FETCH;
        end else if (!stall_i) begin
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = S_FETCH;
        end
      end

      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed table-driven bench for pc_fetch plus hand-written sequences for
// mid-request reset and PC wrap (second instance with RESET_PC=FFFF_FFFF).
module tb_pc_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        branchFlag_i = 1'b0;
  logic [31:0] branchTarget_i = 32'd0;
  logic        memAck_i = 1'b0;
  logic [31:0] memData_i = 32'd0;

  logic        memReq_o, memReq2;
  logic [31:0] memAddr_o, memAddr2;
  logic [31:0] pcPlusOne_o, pcPlusOne2;
  logic [31:0] instruction_o, instruction2;
  logic        stallReq_o, stallReq2;
  logic [1:0]  dbgState_o, dbgState2;

  pc_fetch #(.RESET_PC(32'h0000_0000), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branchFlag_i(branchFlag_i),
    .branchTarget_i(branchTarget_i), .memReq_o(memReq_o), .memAddr_o(memAddr_o),
    .memAck_i(memAck_i), .memData_i(memData_i), .pcPlusOne_o(pcPlusOne_o),
    .instruction_o(instruction_o), .stallReq_o(stallReq_o), .dbgState_o(dbgState_o)
  );

  pc_fetch #(.RESET_PC(32'hFFFF_FFFF), .NOP_WORD(NOP)) dut_wrap (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branchFlag_i(branchFlag_i),
    .branchTarget_i(branchTarget_i), .memReq_o(memReq2), .memAddr_o(memAddr2),
    .memAck_i(memAck_i), .memData_i(memData_i), .pcPlusOne_o(pcPlusOne2),
    .instruction_o(instruction2), .stallReq_o(stallReq2), .dbgState_o(dbgState2)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] data;
    logic        req;
    logic [31:0] addr;
    logic        sreq;
    logic [31:0] instr;
    logic [31:0] ppo;
    logic [1:0]  st;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic stall, input logic br, input logic [31:0] tgt,
                     input logic ack, input logic [31:0] data, input logic req,
                     input logic [31:0] addr, input logic sreq, input logic [31:0] instr,
                     input logic [31:0] ppo, input logic [1:0] st);
    vec_t v;
    v.stall = stall; v.br = br; v.tgt = tgt; v.ack = ack; v.data = data;
    v.req = req; v.addr = addr; v.sreq = sreq; v.instr = instr; v.ppo = ppo; v.st = st;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic stall, input logic br, input logic [31:0] tgt,
                       input logic ack, input logic [31:0] data);
    stall_i = stall; branchFlag_i = br; branchTarget_i = tgt;
    memAck_i = ack; memData_i = data;
  endtask

  initial begin
    // stall br tgt ack data | req addr sreq instr ppo state
    add(0,0,0,        1,32'h0,        0,32'h0,  1,NOP,          32'h0,  2'd0); // boot, ack ignored
    add(0,0,0,        1,32'h0,        1,32'h0,  0,32'h0,        32'h1,  2'd1);
    add(0,0,0,        1,32'h10,       1,32'h1,  0,32'h10,       32'h2,  2'd1);
    add(0,0,0,        1,32'h20,       1,32'h2,  0,32'h20,       32'h3,  2'd1);
    add(0,0,0,        1,32'h30,       1,32'h3,  0,32'h30,       32'h4,  2'd1);
    add(0,0,0,        1,32'h40,       1,32'h4,  0,32'h40,       32'h5,  2'd1);
    add(0,0,0,        0,32'h0,        1,32'h5,  1,NOP,          32'h0,  2'd1); // latency 3 at pc 5
    add(0,0,0,        0,32'h0,        1,32'h5,  1,NOP,          32'h0,  2'd1);
    add(0,0,0,        1,32'h50,       1,32'h5,  0,32'h50,       32'h6,  2'd1);
    add(0,0,0,        1,32'h60,       1,32'h6,  0,32'h60,       32'h7,  2'd1);
    add(0,0,0,        1,32'h70,       1,32'h7,  0,32'h70,       32'h8,  2'd1);
    add(1,0,0,        1,32'hABCD0001, 1,32'h8,  0,32'hABCD0001, 32'h9,  2'd1); // stalled ack
    add(1,0,0,        1,32'hDEAD0000, 0,32'h8,  0,32'hABCD0001, 32'h9,  2'd2); // hold, ack ignored
    add(0,0,0,        0,32'h0,        0,32'h8,  0,32'hABCD0001, 32'h9,  2'd2);
    add(0,0,0,        0,32'h0,        1,32'h9,  1,NOP,          32'h0,  2'd1);
    add(0,1,32'h10,   1,32'h90,       1,32'h9,  1,NOP,          32'h0,  2'd1); // branch+ack
    add(0,1,32'h40,   0,32'h0,        1,32'h10, 1,NOP,          32'h0,  2'd1); // branch, outstanding
    add(0,0,0,        0,32'h0,        1,32'h10, 1,NOP,          32'h0,  2'd1);
    add(0,0,0,        1,32'h100,      1,32'h10, 1,NOP,          32'h0,  2'd1); // stale data dropped
    add(0,0,0,        1,32'h400,      1,32'h40, 0,32'h400,      32'h41, 2'd1);
    add(0,1,32'h20,   0,32'h0,        1,32'h41, 1,NOP,          32'h0,  2'd1);
    add(0,0,0,        1,32'h410,      1,32'h41, 1,NOP,          32'h0,  2'd1);
    add(0,1,32'h80,   1,32'h200,      1,32'h20, 1,NOP,          32'h0,  2'd1); // branch+ack at 0x20
    add(0,0,0,        0,32'h0,        1,32'h80, 1,NOP,          32'h0,  2'd1);
    add(0,0,0,        1,32'h800,      1,32'h80, 0,32'h800,      32'h81, 2'd1);
    add(1,0,0,        1,32'hC0DE,     1,32'h81, 0,32'hC0DE,     32'h82, 2'd1);
    add(1,1,32'h300,  0,32'h0,        0,32'h81, 0,32'hC0DE,     32'h82, 2'd2); // branch from hold
    add(0,0,0,        0,32'h0,        1,32'h300,1,NOP,          32'h0,  2'd1);

    // reset state
    drive(0, 0, 0, 1, 32'h1234);
    repeat (2) @(negedge clk);
    #1;
    check("rst_req",   {31'd0, memReq_o},   32'd0);
    check("rst_sreq",  {31'd0, stallReq_o}, 32'd1);
    check("rst_instr", instruction_o,       NOP);
    check("rst_ppo",   pcPlusOne_o,         32'd0);
    check("rst_addr",  memAddr_o,           32'd0);
    check("rst_state", {30'd0, dbgState_o}, 32'd0);
    check("rst_addr2", memAddr2,            32'hFFFF_FFFF);
    @(negedge clk);
    rst = 1'b1;

    // table
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].ack, vecs[i].data);
      #1;
      check($sformatf("v%0d_req", i),   {31'd0, memReq_o},   {31'd0, vecs[i].req});
      check($sformatf("v%0d_addr", i),  memAddr_o,           vecs[i].addr);
      check($sformatf("v%0d_sreq", i),  {31'd0, stallReq_o}, {31'd0, vecs[i].sreq});
      check($sformatf("v%0d_instr", i), instruction_o,       vecs[i].instr);
      check($sformatf("v%0d_ppo", i),   pcPlusOne_o,         vecs[i].ppo);
      check($sformatf("v%0d_state", i), {30'd0, dbgState_o}, {30'd0, vecs[i].st});
      @(negedge clk);
    end

    // reset asserted mid-request: request drops without a clock edge
    drive(0, 0, 0, 0, 32'h0);
    #2;
    check("mid_req_before", {31'd0, memReq_o}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_req_after",  {31'd0, memReq_o},   32'd0);
    check("mid_sreq_after", {31'd0, stallReq_o}, 32'd1);
    check("mid_addr_after", memAddr_o,           32'd0);
    drive(0, 0, 0, 1, 32'h5555);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 1, 32'h77);
    #1;
    check("post_boot_req",   {31'd0, memReq_o},   32'd0);
    check("post_boot_instr", instruction_o,       NOP);
    check("post_boot_state", {30'd0, dbgState_o}, 32'd0);
    check("wrap_boot_req",   {31'd0, memReq2},    32'd0);
    @(negedge clk);
    #1;
    check("post_fetch_req",   {31'd0, memReq_o}, 32'd1);
    check("post_fetch_addr",  memAddr_o,         32'd0);
    check("post_fetch_instr", instruction_o,     32'h77);
    check("post_fetch_ppo",   pcPlusOne_o,       32'd1);
    check("wrap_addr",        memAddr2,          32'hFFFF_FFFF);
    check("wrap_instr",       instruction2,      32'h77);
    check("wrap_ppo",         pcPlusOne2,        32'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 32'h0);
    #1;
    check("wrap_next_req",  {31'd0, memReq2}, 32'd1);
    check("wrap_next_addr", memAddr2,         32'd0);
    check("post_next_addr", memAddr_o,        32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
